// File: rtl/keypad_sum_entry_if.sv
// Key input and display output bundle for the keypad adder.
// The key source is the master and the adder is the slave.
interface keypad_sum_entry_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] sum_result;
  logic        sum_valid;
  logic [1:0]  phase;

  modport master (
    output key_code, key_valid,
    input  sum_result, sum_valid, phase
  );

  modport slave (
    input  key_code, key_valid,
    output sum_result, sum_valid, phase
  );
endinterface

// File: rtl/keypad_sum_entry.sv
// Two-operand decimal keypad adder (up to 3 digits per operand).
// Every output is registered and is loaded from next-state values, so an accepted key shows one cycle later.
module keypad_sum_entry (
  input  logic               clk,
  input  logic               reset,
  keypad_sum_entry_if.slave  kp
);
  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    SHOW_SUM = 2'b10
  } state_t;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_EQ    = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  state_t      state_reg, state_next;
  logic [9:0]  op_a_reg, op_a_next;
  logic [9:0]  op_b_reg, op_b_next;
  logic [1:0]  digit_cnt_reg, digit_cnt_next;
  logic [10:0] sum_reg, sum_next;
  logic        prev_valid_reg;
  logic [11:0] result_reg, result_next;
  logic        sum_valid_reg, sum_valid_next;
  logic [1:0]  phase_reg;

  logic       accept;
  logic       is_digit;
  logic [9:0] digit_ext;
  logic [9:0] a_shifted;
  logic [9:0] b_shifted;

  assign accept    = kp.key_valid && !prev_valid_reg;
  assign is_digit  = (kp.key_code < 4'd10);
  assign digit_ext = {6'd0, kp.key_code};
  // With at most two digits entered the operand is <= 99, so this fits in 10 bits.
  assign a_shifted = op_a_reg * 10'd10 + digit_ext;
  assign b_shifted = op_b_reg * 10'd10 + digit_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ENTER_A;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      digit_cnt_reg  <= '0;
      sum_reg        <= '0;
      prev_valid_reg <= 1'b0;
      result_reg     <= '0;
      sum_valid_reg  <= 1'b0;
      phase_reg      <= ENTER_A;
    end else begin
      state_reg      <= state_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      digit_cnt_reg  <= digit_cnt_next;
      sum_reg        <= sum_next;
      prev_valid_reg <= kp.key_valid;
      result_reg     <= result_next;
      sum_valid_reg  <= sum_valid_next;
      phase_reg      <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_a_next      = op_a_reg;
    op_b_next      = op_b_reg;
    digit_cnt_next = digit_cnt_reg;
    sum_next       = sum_reg;

    case (state_reg)
      ENTER_A: begin
        if (accept && is_digit && digit_cnt_reg != 2'd3) begin
          op_a_next      = a_shifted;
          digit_cnt_next = digit_cnt_reg + 2'd1;
        end else if (accept && kp.key_code == KEY_ADD) begin
          state_next     = ENTER_B;
          op_b_next      = '0;
          digit_cnt_next = '0;
        end
      end
      ENTER_B: begin
        if (accept && is_digit && digit_cnt_reg != 2'd3) begin
          op_b_next      = b_shifted;
          digit_cnt_next = digit_cnt_reg + 2'd1;
        end else if (accept && kp.key_code == KEY_EQ) begin
          sum_next   = {1'b0, op_a_reg} + {1'b0, op_b_reg};
          state_next = SHOW_SUM;
        end
      end
      SHOW_SUM: begin
        if (accept && is_digit) begin
          op_a_next      = digit_ext;
          op_b_next      = '0;
          digit_cnt_next = 2'd1;
          state_next     = ENTER_A;
        end
      end
      default: begin
        // Illegal encoding: recover to a fully cleared ENTER_A.
        state_next     = ENTER_A;
        op_a_next      = '0;
        op_b_next      = '0;
        digit_cnt_next = '0;
        sum_next       = '0;
      end
    endcase

    if (accept && kp.key_code == KEY_CLEAR) begin
      state_next     = ENTER_A;
      op_a_next      = '0;
      op_b_next      = '0;
      digit_cnt_next = '0;
      sum_next       = '0;
    end

    sum_valid_next = (state_next == SHOW_SUM);
    case (state_next)
      ENTER_B:  result_next = {2'b00, op_b_next};
      SHOW_SUM: result_next = {1'b0, sum_next};
      default:  result_next = {2'b00, op_a_next};
    endcase
  end

  assign kp.sum_result = result_reg;
  assign kp.sum_valid  = sum_valid_reg;
  assign kp.phase      = phase_reg;
endmodule

// File: tb/tb_keypad_sum_entry.sv
// Directed bench: each key press pushes its expected display state to a queue,
// which is popped and compared once the DUT output has updated.
module tb_keypad_sum_entry;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [11:0] res;
    logic        vld;
    logic [1:0]  ph;
  } exp_t;

  exp_t sb_q[$];

  keypad_sum_entry_if kp ();

  keypad_sum_entry dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    assert (got === expv)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, int'(kp.sum_result), int'(e.res));
      chk({tag, "_valid"},  int'(kp.sum_valid),  int'(e.vld));
      chk({tag, "_phase"},  int'(kp.phase),      int'(e.ph));
      $display("key %s -> sum_result=%0d sum_valid=%0d phase=%0d", tag,
               kp.sum_result, kp.sum_valid, kp.phase);
    end
  endtask

  // Press one key, check the accepted effect, hold it, check it was not re-accepted.
  task automatic press(input logic [3:0] code, input int res, input bit vld,
                       input logic [1:0] ph, input int hold);
    exp_t e;
    e.res = 12'(res);
    e.vld = vld;
    e.ph  = ph;
    @(negedge clk);
    kp.key_code  = code;
    kp.key_valid = 1'b1;
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check($sformatf("%h", code));
    repeat (hold) @(posedge clk);
    #1;
    pop_check($sformatf("%h_held", code));
    @(negedge clk);
    kp.key_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic expect_now(input string tag, input int res, input bit vld, input logic [1:0] ph);
    exp_t e;
    e.res = 12'(res);
    e.vld = vld;
    e.ph  = ph;
    sb_q.push_back(e);
    pop_check(tag);
  endtask

  initial begin
    reset        = 1'b1;
    kp.key_code  = 4'h0;
    kp.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_now("reset", 0, 0, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // 123 + 456
    press(4'h1, 1, 0, 2'b00, 1);
    press(4'h2, 12, 0, 2'b00, 1);
    press(4'h3, 123, 0, 2'b00, 1);
    press(4'hA, 0, 0, 2'b01, 1);
    press(4'h4, 4, 0, 2'b01, 1);
    press(4'h5, 45, 0, 2'b01, 1);
    press(4'h6, 456, 0, 2'b01, 1);
    press(4'hB, 579, 1, 2'b10, 1);
    // ignored keys in SHOW_SUM
    press(4'hA, 579, 1, 2'b10, 1);
    press(4'hB, 579, 1, 2'b10, 1);
    press(4'hE, 579, 1, 2'b10, 1);
    press(4'hF, 579, 1, 2'b10, 1);

    // digit from SHOW_SUM starts a new A; 999 + 999 with a fourth digit ignored
    press(4'h9, 9, 0, 2'b00, 1);
    press(4'h9, 99, 0, 2'b00, 1);
    press(4'h9, 999, 0, 2'b00, 1);
    press(4'h9, 999, 0, 2'b00, 1);
    press(4'hE, 999, 0, 2'b00, 1);
    press(4'hF, 999, 0, 2'b00, 1);
    press(4'hB, 999, 0, 2'b00, 1);
    press(4'hA, 0, 0, 2'b01, 1);
    press(4'hE, 0, 0, 2'b01, 1);
    press(4'hA, 0, 0, 2'b01, 1);
    press(4'h9, 9, 0, 2'b01, 1);
    press(4'h9, 99, 0, 2'b01, 1);
    press(4'h9, 999, 0, 2'b01, 1);
    press(4'hF, 999, 0, 2'b01, 1);
    press(4'hB, 1998, 1, 2'b10, 1);

    // clear, then a long hold is accepted exactly once
    press(4'hC, 0, 0, 2'b00, 1);
    press(4'h7, 7, 0, 2'b00, 50);
    press(4'hC, 0, 0, 2'b00, 1);

    // empty B operand, then digit / equals from SHOW_SUM
    press(4'h5, 5, 0, 2'b00, 1);
    press(4'hA, 0, 0, 2'b01, 1);
    press(4'hB, 5, 1, 2'b10, 1);
    press(4'h3, 3, 0, 2'b00, 1);
    press(4'hB, 3, 0, 2'b00, 1);

    // clear mid-entry
    press(4'hC, 0, 0, 2'b00, 1);
    press(4'h4, 4, 0, 2'b00, 1);
    press(4'h2, 42, 0, 2'b00, 1);
    press(4'hC, 0, 0, 2'b00, 1);

    // reset mid-entry, coincident with a key edge that must be discarded
    press(4'h4, 4, 0, 2'b00, 1);
    press(4'h2, 42, 0, 2'b00, 1);
    @(negedge clk);
    kp.key_code  = 4'h5;
    kp.key_valid = 1'b1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    expect_now("reset_edge", 0, 0, 2'b00);
    @(negedge clk);
    reset        = 1'b0;
    kp.key_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_now("after_reset", 0, 0, 2'b00);

    // key already held when reset releases is accepted on the first cycle
    @(negedge clk);
    reset        = 1'b1;
    kp.key_code  = 4'h8;
    kp.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect_now("held_through_reset", 8, 0, 2'b00);
    @(negedge clk);
    kp.key_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
